// File: rtl/btn_pkg.sv
// Shared constants, repeat-state encoding and width helper for the button conditioner.
package btn_pkg;

    localparam int DEBOUNCE_CYCLES = 125000;
    localparam int REPEAT_DELAY    = 12500000;
    localparam int REPEAT_PERIOD   = 2500000;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } repeat_state_t;

    // Bits needed to hold values 0 .. n-1, never less than one.
    function automatic int clog2_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Board-button bus: raw pad levels in, conditioned levels and edge pulses out.
interface btn_conditioner_if #(
    parameter int N_BTN = 7
);
    logic [N_BTN-1:0] BTN_RAW;
    logic [N_BTN-1:0] BTNS;
    logic [N_BTN-1:0] BTN_PRESS;
    logic [N_BTN-1:0] BTN_RELEASE;

    modport master (output BTN_RAW, input BTNS, BTN_PRESS, BTN_RELEASE);
    modport slave  (input BTN_RAW, output BTNS, BTN_PRESS, BTN_RELEASE);
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, polarity fix, stability counter and edge pulses.
// With BTN_AUTOREPEAT_EN the next-edge accept strobes are exported for the repeat FSM.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic CLK_VGA,
    input  logic RST_VGA,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
`ifdef BTN_AUTOREPEAT_EN
    ,
    output logic rise_nxt,
    output logic fall_nxt
`endif
);

    localparam int             CW   = clog2_w(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] count;
    logic          active;
    logic          accept;

    assign active = sync_q2 ^ ACTIVE_LOW;
    assign accept = (active != level) && (count == LAST);

`ifdef BTN_AUTOREPEAT_EN
    assign rise_nxt = accept && !level;
    assign fall_nxt = accept && level;
`endif

    always_ff @(posedge CLK_VGA or negedge RST_VGA) begin
        if (!RST_VGA) begin
            // NOTE: synchronizer resets to the pad's idle level so a button held through reset is seen as a fresh press.
            sync_q1       <= ACTIVE_LOW;
            sync_q2       <= ACTIVE_LOW;
            count         <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values; blocking here would collapse the synchronizer.
            sync_q1       <= raw;
            sync_q2       <= sync_q1;
            press_pulse   <= accept && !level;
            release_pulse <= accept && level;
            if (active == level || accept) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
            if (accept) begin
                level <= ~level;
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Board button front end: N_BTN debounced, active-high levels plus press/release pulses.
// Optional macro BTN_AUTOREPEAT_EN adds a per-button hold-to-repeat FSM on BTN_PRESS.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int               N_BTN           = 7,
    parameter int               DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = N_BTN'(7'b0000001)
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int               REPEAT_DELAY    = btn_pkg::REPEAT_DELAY,
    parameter int               REPEAT_PERIOD   = btn_pkg::REPEAT_PERIOD
`endif
) (
    input  logic               CLK_VGA,
    input  logic               RST_VGA,
    btn_conditioner_if.slave   bus
);

    logic [N_BTN-1:0] btns;
    logic [N_BTN-1:0] deb_press;
    logic [N_BTN-1:0] deb_release;
    logic [N_BTN-1:0] press_out;

    assign bus.BTNS        = btns;
    assign bus.BTN_PRESS   = press_out;
    assign bus.BTN_RELEASE = deb_release;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
`ifdef BTN_AUTOREPEAT_EN
        localparam int RW = clog2_w((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

        logic          rise_nxt;
        logic          fall_nxt;
        logic          rep_pulse;
        logic [RW-1:0] rep_count;
        repeat_state_t state;
`endif

        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
        ) u_debounce (
            .CLK_VGA       (CLK_VGA),
            .RST_VGA       (RST_VGA),
            .raw           (bus.BTN_RAW[i]),
            .level         (btns[i]),
            .press_pulse   (deb_press[i]),
            .release_pulse (deb_release[i])
`ifdef BTN_AUTOREPEAT_EN
            ,
            .rise_nxt      (rise_nxt),
            .fall_nxt      (fall_nxt)
`endif
        );

`ifdef BTN_AUTOREPEAT_EN
        // Driven by the debouncer's accept strobes so a release never coincides with a repeat pulse.
        always_ff @(posedge CLK_VGA or negedge RST_VGA) begin
            if (!RST_VGA) begin
                state     <= IDLE;
                rep_count <= '0;
                rep_pulse <= 1'b0;
            end else begin
                rep_pulse <= 1'b0;
                if (fall_nxt) begin
                    state     <= IDLE;
                    rep_count <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (rise_nxt) begin
                                state     <= HOLD;
                                rep_count <= '0;
                            end
                        end
                        HOLD: begin
                            if (rep_count == RW'(REPEAT_DELAY - 1)) begin
                                state     <= REPEAT;
                                rep_count <= '0;
                                rep_pulse <= 1'b1;
                            end else begin
                                rep_count <= rep_count + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (rep_count == RW'(REPEAT_PERIOD - 1)) begin
                                rep_count <= '0;
                                rep_pulse <= 1'b1;
                            end else begin
                                rep_count <= rep_count + 1'b1;
                            end
                        end
                        default: begin
                            state     <= IDLE;
                            rep_count <= '0;
                        end
                    endcase
                end
            end
        end

        assign press_out[i] = deb_press[i] | rep_pulse;
`else
        assign press_out[i] = deb_press[i];
`endif
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_BTN, default 7, number of board buttons.
REQ-002 Parameter DEBOUNCE_CYCLES, default 125000, stable cycles required before accepting a new level (5 ms at 25 MHz).
REQ-003 Parameter ACTIVE_LOW_MASK, default 7'b0000001, bit set = raw input is active-low and SHALL be inverted (btn[0] is the power button).
REQ-004 CLK_VGA  input  1  pixel-domain clock, 25 MHz, sole clock.
REQ-005 RST_VGA  input  1  asynchronous, active-low reset.
REQ-006 BTN_RAW  input  N_BTN  raw pad levels, asynchronous to CLK_VGA.
REQ-007 BTNS  output  N_BTN  debounced, synchronized, active-high levels; feeds the game core's BTNS port.
REQ-008 BTN_PRESS  output  N_BTN  one-cycle pulse per accepted press.
REQ-009 BTN_RELEASE  output  N_BTN  one-cycle pulse per accepted release.

Function
REQ-010 Each BTN_RAW bit SHALL pass through a 2-flop synchronizer, then polarity correction per ACTIVE_LOW_MASK; all logic after the synchronizer is per-bit and independent.
REQ-011 Per bit, the counter SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits wide and SHALL clear whenever the synchronized level equals the current BTNS bit.
REQ-012 While the synchronized level differs from BTNS, the counter SHALL increment by 1 per cycle; when it reaches DEBOUNCE_CYCLES-1, BTNS SHALL toggle on the next edge and the counter SHALL clear.
REQ-013 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL clear the count and produce no BTNS change; the counter SHALL never wrap.
REQ-014 Latency from a stable raw transition to the BTNS change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-015 BTN_PRESS SHALL assert for exactly the one cycle in which BTNS goes 0->1; BTN_RELEASE likewise on 1->0. The two SHALL never be high together on one bit.
REQ-016 Multiple bits changing in the same cycle SHALL each produce their own pulses in that cycle.

Reset
REQ-017 On RST_VGA low, asynchronously: synchronizer flops = inactive level (after polarity), counters = 0, BTNS = 0, BTN_PRESS = 0, BTN_RELEASE = 0, repeat state = IDLE.
REQ-018 A button held through reset release SHALL be accepted as a press after 2 + DEBOUNCE_CYCLES cycles, with one BTN_PRESS pulse.
REQ-019 Reset asserted mid-count SHALL discard the count; no pulse SHALL be emitted for it.

Configuration
REQ-020 Macro BTN_AUTOREPEAT_EN: when defined, each bit has a repeat FSM IDLE -> HOLD (on accepted press) -> REPEAT.
REQ-021 HOLD lasts REPEAT_DELAY cycles (package constant, 12500000), then emits one BTN_PRESS and enters REPEAT; REPEAT emits a BTN_PRESS every REPEAT_PERIOD cycles (2500000); an accepted release from any state returns to IDLE with no further pulse.
REQ-022 Without BTN_AUTOREPEAT_EN, no repeat FSM or counters SHALL be synthesized, and BTN_PRESS fires only once per press.

Structure
REQ-023 Package btn_pkg SHALL hold DEBOUNCE_CYCLES default, REPEAT_DELAY, REPEAT_PERIOD, the repeat-state enum (IDLE, HOLD, REPEAT) and a clog2 width helper.
REQ-024 The per-bit synchronizer + debounce counter + edge detect SHALL be sub-module btn_debounce, instantiated N_BTN times by generate; btn_conditioner holds polarity mask and optional repeat FSMs.

Verification (bench overrides DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-025 BTN_RAW[3] 0->1 held -> BTNS[3]=1 exactly 10 cycles later, BTN_PRESS[3] high that cycle only.
REQ-026 BTN_RAW[2] high for 7 cycles, then low -> BTNS[2] stays 0, no pulses.
REQ-027 BTN_RAW[0] driven 1 then 0 (active-low) -> BTNS[0]=1 after 10 cycles; return to 1 -> BTN_RELEASE[0] pulse 10 cycles later.
REQ-028 RST_VGA low for 3 cycles at count 5 during a BTN_RAW[1] press -> all outputs 0 immediately; after release, press accepted 10 cycles later, single pulse.
REQ-029 BTN_RAW[4] and BTN_RAW[5] rise together -> both BTN_PRESS bits pulse in the same cycle.
REQ-030 With BTN_AUTOREPEAT_EN, BTN_RAW[6] held 50 cycles past acceptance -> pulses at +0, +20, +25, +30, +35, +40, +45, +50; after release none.
